delay_link_tx: RTL and testbench

//   Transmit side of the fixed-latency delay link. Accepts flits from a router

---
 rtl/delay_link_tx.sv | 197 +++++++++++++++++++
 tb/tb_delay_link_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_link_tx.sv
// ---------------------------------------------------------------------------
// delay_link_tx
//   Transmit side of the fixed-latency delay link. Flits arrive from a router
//   output port over valid/ready and are queued in a small FIFO. One word at a
//   time is presented to the delay stage on tx_data/tx_valid and is held
//   stable until that stage pulses tx_ack. Delivered words are counted, and a
//   sticky timeout flag is raised if a presented word waits too long for ack.
//
// Parameters
//   DATA_W   flit width
//   DEPTH    FIFO entries (power of 2, >= 2)
//   TIMEOUT  cycles a presented word may wait for ack before timeout_err
//
// Ports
//   clk          in   clock
//   reset        in   synchronous reset, active-low
//   in_data      in   flit from upstream router
//   in_valid     in   in_data valid
//   in_ready     out  FIFO can accept (combinational, = !full)
//   tx_data      out  word presented to the delay stage (registered)
//   tx_valid     out  tx_data holds a real flit (registered)
//   tx_ack       in   1-cycle pulse: delay stage sampled tx_data
//   sent_count   out  delivered-flit counter (wraps)
//   timeout_err  out  sticky: a word waited TIMEOUT cycles without ack
//   fifo_level   out  entries currently queued (held word excluded)
// ---------------------------------------------------------------------------
module delay_link_tx #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ack,
    output logic [15:0]              sent_count,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // The transmitter state is exactly "is a word being presented", so the
    // state register doubles as tx_valid.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [WAIT_W-1:0]    wait_cnt;

    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic                 ack_take;
    logic                 wait_tick;

    // Saturating increment of the ack-wait counter; it parks at TIMEOUT so a
    // very long stall cannot wrap it back to a small value.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v >= WAIT_W'(TIMEOUT))
            return WAIT_W'(TIMEOUT);
        else
            return v + 1'b1;
    endfunction

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LVL_W'(DEPTH));

    // Ready depends only on the registered level, so a pop on the same edge
    // never lets a word slip into a full FIFO.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;

    assign tx_valid   = (state == HOLD);
    assign fifo_level = level;

    // An ack only counts while a word is actually presented.
    assign ack_take   = (state == HOLD) && tx_ack;
    assign wait_tick  = (state == HOLD) && !tx_ack;

    // -----------------------------------------------------------------------
    // Transmit FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // -----------------------------------------------------------------------
    // Transmit FSM: next state and FIFO pop
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                // No bypass: only words already sitting in the FIFO are loaded.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (tx_ack) begin
                    if (!fifo_empty)
                        pop = 1'b1;
                    else
                        state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO storage and pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (!push && pop)
                level <= level - 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Presented word: loaded on every pop, otherwise held (also in IDLE)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset)
            tx_data <= '0;
        else if (pop)
            tx_data <= mem[rd_ptr];
    end

    // -----------------------------------------------------------------------
    // Delivery counter, ack-wait counter and sticky timeout flag
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset)
            sent_count <= '0;
        else if (ack_take)
            sent_count <= sent_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            wait_cnt <= '0;
        else if (pop)
            wait_cnt <= '0;
        else if (wait_tick)
            wait_cnt <= sat_inc(wait_cnt);
    end

    // The flag rises on the edge that completes TIMEOUT un-acked HOLD cycles;
    // the word itself keeps being presented until it is acked.
    always_ff @(posedge clk) begin
        if (!reset)
            timeout_err <= 1'b0;
        else if (wait_tick && (wait_cnt >= WAIT_W'(TIMEOUT - 1)))
            timeout_err <= 1'b1;
    end

endmodule

// File: tb/tb_delay_link_tx.sv
module tb_delay_link_tx;

    localparam int DATA_W     = 16;
    localparam int DEPTH      = 4;
    localparam int TIMEOUT    = 64;
    localparam int ACK_PERIOD = 37;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ack;
    logic [15:0]       sent_count;
    logic              timeout_err;
    logic [2:0]        fifo_level;

    int checks   = 0;
    int failures = 0;

    // delay-stage model controls
    bit ack_en  = 1'b0;
    int ack_ctr = 0;

    // reference model state
    logic [15:0] m_q[$];
    logic [15:0] m_data  = '0;
    bit          m_valid = 1'b0;
    logic [15:0] m_count = '0;
    int          m_age   = 0;
    bit          m_err   = 1'b0;
    bit          m_live  = 1'b0;

    // words observed leaving the DUT on ack edges
    logic [15:0] delivered[$];

    always #5 clk = ~clk;

    delay_link_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ack     (tx_ack),
        .sent_count (sent_count),
        .timeout_err(timeout_err),
        .fifo_level (fifo_level)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge. The delay
    // stage acks once every ACK_PERIOD cycles while enabled.
    task automatic tick();
        @(posedge clk);
        #1;
        ack_ctr = (ack_ctr == ACK_PERIOD - 1) ? 0 : ack_ctr + 1;
        tx_ack  = ack_en && (ack_ctr == ACK_PERIOD - 1);
    endtask

    task automatic pulse_ack();
        tx_ack = 1'b1;
        @(posedge clk);
        #1;
        tx_ack = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] w);
        int n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400)
            check("push_wait_expired", 32'(n), 32'd0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_valid || fifo_level != 0) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000)
            check("idle_wait_expired", 32'(n), 32'd0);
    endtask

    // Compare DUT against the model, then advance the model using the inputs
    // that the coming rising edge will sample.
    initial begin : model_compare
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("tx_valid",    32'(tx_valid),    32'(m_valid));
                check("tx_data",     32'(tx_data),     32'(m_data));
                check("sent_count",  32'(sent_count),  32'(m_count));
                check("timeout_err", 32'(timeout_err), 32'(m_err));
                check("in_ready",    32'(in_ready),    32'(m_q.size() < DEPTH));
                check("fifo_level",  32'(fifo_level),  32'(m_q.size()));
            end
            if (reset && tx_valid && tx_ack)
                delivered.push_back(tx_data);
            if (!reset) begin
                m_q.delete();
                m_data  = '0;
                m_valid = 1'b0;
                m_count = '0;
                m_age   = 0;
                m_err   = 1'b0;
                m_live  = 1'b1;
            end else if (m_live) begin
                bit do_push;
                do_push = in_valid && (m_q.size() < DEPTH);
                if (m_valid) begin
                    if (tx_ack) begin
                        m_count = m_count + 16'd1;
                        if (m_q.size() > 0) begin
                            m_data = m_q.pop_front();
                            m_age  = 0;
                        end else begin
                            m_valid = 1'b0;
                        end
                    end else begin
                        if (m_age < TIMEOUT)
                            m_age++;
                        if (m_age == TIMEOUT)
                            m_err = 1'b1;
                    end
                end else if (m_q.size() > 0) begin
                    m_data  = m_q.pop_front();
                    m_valid = 1'b1;
                    m_age   = 0;
                end
                if (do_push)
                    m_q.push_back(in_data);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stimulus
        logic [15:0] exp_words[7];
        exp_words = '{16'h1234, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tx_ack   = 1'b0;
        repeat (3) tick();

        // 1: reset state
        check("rst_tx_valid",    32'(tx_valid),    32'd0);
        check("rst_tx_data",     32'(tx_data),     32'd0);
        check("rst_sent_count",  32'(sent_count),  32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_in_ready",    32'(in_ready),    32'd1);
        check("rst_fifo_level",  32'(fifo_level),  32'd0);

        reset  = 1'b1;
        ack_en = 1'b1;
        tick();

        // 2: single word, no bypass, delivered on ack
        push_word(16'h1234);
        check("t2_no_bypass", 32'(tx_valid), 32'd0);
        tick();
        check("t2_loaded_valid", 32'(tx_valid), 32'd1);
        check("t2_loaded_data",  32'(tx_data),  32'h1234);
        wait_idle();
        check("t2_sent_count", 32'(sent_count), 32'd1);
        check("t2_data_kept",  32'(tx_data),    32'h1234);

        // 3: fill to capacity, one word pending, then drain in order
        ack_en = 1'b0;
        tx_ack = 1'b0;
        for (int i = 0; i < 5; i++)
            push_word(16'hA000 + 16'(i));
        check("t3_full_ready", 32'(in_ready),   32'd0);
        check("t3_full_level", 32'(fifo_level), 32'd4);
        check("t3_held_data",  32'(tx_data),    32'hA000);
        in_data  = 16'hA005;
        in_valid = 1'b1;
        tick();
        tick();
        check("t3_pending_ready", 32'(in_ready),   32'd0);
        check("t3_pending_level", 32'(fifo_level), 32'd4);
        ack_en  = 1'b1;
        ack_ctr = 0;
        push_word(16'hA005);
        wait_idle();
        check("t3_sent_count", 32'(sent_count), 32'd7);
        check("t3_delivered_n", 32'(delivered.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < delivered.size())
                check("t3_order", 32'(delivered[i]), 32'(exp_words[i]));

        // 4: acks while idle are ignored
        ack_en = 1'b0;
        tx_ack = 1'b0;
        tick();
        repeat (3) begin
            pulse_ack();
            tick();
        end
        check("t4_sent_count", 32'(sent_count), 32'd7);
        check("t4_tx_valid",   32'(tx_valid),   32'd0);

        // 5: timeout at edge TIMEOUT after load, word kept until ack
        push_word(16'hBEEF);
        tick();
        check("t5_loaded", 32'(tx_data), 32'hBEEF);
        repeat (TIMEOUT - 1) tick();
        check("t5_err_before", 32'(timeout_err), 32'd0);
        tick();
        check("t5_err_at",  32'(timeout_err), 32'd1);
        check("t5_held",    32'(tx_data),     32'hBEEF);
        check("t5_valid",   32'(tx_valid),    32'd1);
        repeat (15) tick();
        pulse_ack();
        check("t5_sent_count", 32'(sent_count),  32'd8);
        check("t5_idle",       32'(tx_valid),    32'd0);
        check("t5_err_sticky", 32'(timeout_err), 32'd1);

        // 6: reset mid-HOLD discards queued and held words
        push_word(16'hC000);
        push_word(16'hC001);
        push_word(16'hC002);
        push_word(16'hC003);
        check("t6_level_before", 32'(fifo_level), 32'd3);
        reset = 1'b0;
        tick();
        check("t6_rst_level", 32'(fifo_level),  32'd0);
        check("t6_rst_valid", 32'(tx_valid),    32'd0);
        check("t6_rst_count", 32'(sent_count),  32'd0);
        check("t6_rst_err",   32'(timeout_err), 32'd0);
        check("t6_rst_ready", 32'(in_ready),    32'd1);
        reset  = 1'b1;
        ack_en = 1'b1;
        repeat (40) tick();
        check("t6_no_stale_valid", 32'(tx_valid),   32'd0);
        check("t6_no_stale_level", 32'(fifo_level), 32'd0);
        check("t6_no_stale_count", 32'(sent_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
